// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer family: FSM states and the
// fixed-point scale/saturate helper used at the end of every neuron.
package fc_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  // Widest accumulator and result the helper supports.
  localparam int SAT_W     = 128;
  localparam int SAT_OUT_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_OUT_W-1:0] value;
  } sat_t;

  // Arithmetic shift right by frac (floor), then clamp to a signed bits-wide range.
  function automatic sat_t sat_scale(input logic signed [SAT_W-1:0] acc,
                                     input int unsigned frac,
                                     input int unsigned bits);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_t r;
    one     = {{(SAT_W-1){1'b0}}, 1'b1};
    shifted = acc >>> frac;
    max_v   = (one <<< (bits - 1)) - one;
    min_v   = -max_v - one;
    r.ovf   = (shifted > max_v) || (shifted < min_v);
    if (shifted > max_v)      r.value = max_v[SAT_OUT_W-1:0];
    else if (shifted < min_v) r.value = min_v[SAT_OUT_W-1:0];
    else                      r.value = shifted[SAT_OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fc_layer_param_mac.sv
// fc_mac_pipe: 3-stage multiply / accumulate / scale-saturate datapath.
// Optional ReLU on the saturated result when FC_RELU_EN is defined.
module fc_mac_pipe
  import fc_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACC_BITS  = 74
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 first,
  input  logic                 last,
  input  logic [DATA_BITS-1:0] x,
  input  logic [DATA_BITS-1:0] w_data,
  output logic [DATA_BITS-1:0] result,
  output logic                 sat
);

  logic                        s0_valid, s0_first, s0_last;
  logic signed [DATA_BITS-1:0] s0_x;
  logic                        s1_valid, s1_first, s1_last;
  logic signed [ACC_BITS-1:0]  s1_term;
  logic                        s2_last;
  logic signed [ACC_BITS-1:0]  acc;

  logic signed [2*DATA_BITS-1:0] prod;
  logic signed [ACC_BITS-1:0]    term;
  sat_t                          scaled;
  logic [DATA_BITS-1:0]          res_next;

  // The last read of a neuron returns the bias, aligned to the product's Q point.
  always_comb begin
    prod = s0_x * signed'(w_data);
    if (s0_last) term = ACC_BITS'(signed'(w_data)) <<< FRAC_BITS;
    else         term = ACC_BITS'(prod);
  end

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    scaled   = sat_scale(SAT_W'(acc), FRAC_BITS, DATA_BITS);
    res_next = scaled.value[DATA_BITS-1:0];
`ifdef FC_RELU_EN
    if (res_next[DATA_BITS-1]) res_next = '0;
`else
    res_next = res_next;
`endif
  end

  // NOTE: clocked state uses non-blocking assignments so all stages update
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
      s0_x     <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_term  <= '0;
      s2_last  <= 1'b0;
      acc      <= '0;
      result   <= '0;
      sat      <= 1'b0;
    end else begin
      s0_valid <= en;
      s0_first <= en && first;
      s0_last  <= en && last;
      s0_x     <= x;
      s1_valid <= s0_valid;
      s1_first <= s0_first;
      s1_last  <= s0_last;
      if (s0_valid) s1_term <= term;
      s2_last  <= s1_last;
      if (s1_valid) acc <= s1_first ? s1_term : acc + s1_term;
      sat <= 1'b0;
      if (s2_last) begin
        result <= res_next;
        sat    <= scaled.ovf;
      end
    end
  end

endmodule

// File: rtl/fc_layer_param.sv
// Parametrised FC layer: buffers an input vector, runs OUTPUT_NUM dot products
// through fc_mac_pipe and streams results out. Macro FC_RELU_EN enables ReLU.
module fc_layer_param
  import fc_pkg::*;
#(
  parameter int INPUT_NUM  = 512,
  parameter int IN_LANES   = 128,
  parameter int OUTPUT_NUM = 1,
  parameter int DATA_BITS  = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ACC_BITS   = 2*DATA_BITS + $clog2(INPUT_NUM) + 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          valid_in,
  output logic                                          ready_in,
  input  logic [IN_LANES*DATA_BITS-1:0]                 data_in,
  output logic                                          w_rd_en,
  output logic [$clog2(OUTPUT_NUM*(INPUT_NUM+1))-1:0]   w_addr,
  input  logic [DATA_BITS-1:0]                          w_data,
  output logic                                          valid_out,
  input  logic                                          ready_out,
  output logic [DATA_BITS-1:0]                          data_out,
  output logic [$clog2(OUTPUT_NUM):0]                   out_idx,
  output logic                                          busy,
  output logic                                          overflow
);

  localparam int BEATS = INPUT_NUM / IN_LANES;
  localparam int AW    = $clog2(OUTPUT_NUM*(INPUT_NUM+1));
  localparam int OW    = $clog2(OUTPUT_NUM) + 1;
  localparam int KW    = $clog2(INPUT_NUM+4) + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int XW    = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;

  if (INPUT_NUM % IN_LANES != 0) begin : g_bad_lanes
    $fatal(1, "INPUT_NUM must be a multiple of IN_LANES");
  end

  state_t               state, next_state;
  logic                 started;
  logic [BW-1:0]        beat_cnt;
  logic [KW-1:0]        k;
  logic [OW-1:0]        o;
  logic [AW-1:0]        row_base;
  logic [DATA_BITS-1:0] xbuf [INPUT_NUM];
  logic [DATA_BITS-1:0] x_cur;
  logic                 mac_sat;

  logic take, last_beat, compute_end, last_neuron;

  assign take        = valid_in && ready_in;
  assign last_beat   = (beat_cnt == BW'(BEATS-1));
  assign compute_end = (k == KW'(INPUT_NUM+3));
  assign last_neuron = (o == OW'(OUTPUT_NUM-1));
  assign x_cur       = (k < KW'(INPUT_NUM)) ? xbuf[k[XW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (take && last_beat) next_state = COMPUTE;
      COMPUTE: if (compute_end)       next_state = OUTPUT;
      OUTPUT:  if (ready_out)         next_state = last_neuron ? LOAD : COMPUTE;
      default:                        next_state = LOAD;
    endcase
  end

  // started keeps ready_in low until the first clock after reset release.
  always_comb begin
    ready_in  = (state == LOAD) && started;
    w_rd_en   = (state == COMPUTE) && (k <= KW'(INPUT_NUM));
    w_addr    = row_base + AW'(k);
    valid_out = (state == OUTPUT);
    busy      = (state != LOAD);
    out_idx   = o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started  <= 1'b0;
      beat_cnt <= '0;
      k        <= '0;
      o        <= '0;
      row_base <= '0;
      overflow <= 1'b0;
    end else begin
      started <= 1'b1;
      if (take) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      k <= (state == COMPUTE && !compute_end) ? k + 1'b1 : '0;
      if (state == OUTPUT && ready_out) begin
        if (last_neuron) begin
          o        <= '0;
          row_base <= '0;
        end else begin
          o        <= o + 1'b1;
          row_base <= row_base + AW'(INPUT_NUM+1);
        end
      end
      if (take && beat_cnt == '0) overflow <= 1'b0;
      else if (mac_sat)           overflow <= 1'b1;
    end
  end

  // NOTE: the vector buffer is deliberately not reset; it is always fully
  // rewritten before use and a reset would only cost a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (take) begin
      for (int j = 0; j < IN_LANES; j++)
        xbuf[XW'(int'(beat_cnt)*IN_LANES + j)] <= data_in[j*DATA_BITS +: DATA_BITS];
    end
  end

  fc_mac_pipe #(
    .DATA_BITS (DATA_BITS),
    .FRAC_BITS (FRAC_BITS),
    .ACC_BITS  (ACC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_rd_en),
    .first  (k == '0),
    .last   (k == KW'(INPUT_NUM)),
    .x      (x_cur),
    .w_data (w_data),
    .result (data_out),
    .sat    (mac_sat)
  );

endmodule

// File: tb/tb_fc_layer_param.sv
// Self-checking bench for fc_layer_param: a small 8/4/2 instance for directed
// timing/saturation/reset cases and a default-size instance with random data.
module tb_fc_layer_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Small instance: INPUT_NUM=8, IN_LANES=4, OUTPUT_NUM=2
  logic         s_valid_in, s_ready_in, s_w_rd_en, s_valid_out, s_ready_out, s_busy, s_overflow;
  logic [127:0] s_data_in;
  logic [4:0]   s_w_addr;
  logic [31:0]  s_w_data, s_data_out;
  logic [1:0]   s_out_idx;
  int           s_mem [18];
  int           s_x   [8];

  // Default instance: 512/128/1
  logic          b_valid_in, b_ready_in, b_w_rd_en, b_valid_out, b_ready_out, b_busy, b_overflow;
  logic [4095:0] b_data_in;
  logic [9:0]    b_w_addr;
  logic [31:0]   b_w_data, b_data_out;
  logic [0:0]    b_out_idx;
  int            b_mem [513];
  int            b_x   [512];

  fc_layer_param #(.INPUT_NUM(8), .IN_LANES(4), .OUTPUT_NUM(2)) u_small (
    .clk(clk), .rst_n(rst_n), .valid_in(s_valid_in), .ready_in(s_ready_in),
    .data_in(s_data_in), .w_rd_en(s_w_rd_en), .w_addr(s_w_addr), .w_data(s_w_data),
    .valid_out(s_valid_out), .ready_out(s_ready_out), .data_out(s_data_out),
    .out_idx(s_out_idx), .busy(s_busy), .overflow(s_overflow));

  fc_layer_param u_big (
    .clk(clk), .rst_n(rst_n), .valid_in(b_valid_in), .ready_in(b_ready_in),
    .data_in(b_data_in), .w_rd_en(b_w_rd_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out),
    .out_idx(b_out_idx), .busy(b_busy), .overflow(b_overflow));

  // Synchronous weight memories with one cycle of read latency.
  always @(posedge clk) if (s_w_rd_en) s_w_data <= s_mem[s_w_addr];
  always @(posedge clk) if (b_w_rd_en) b_w_data <= b_mem[b_w_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of x*w plus bias scaled to the product's Q point, floor-divided
  // by 2^16, clamped to int32, optionally clipped at zero.
  function automatic logic [31:0] ref_neuron(input int xs[$], input int ws[$],
                                             input int bias, output bit sat);
    logic signed [127:0] sum, q, hi, lo;
    sum = 128'(bias) * 128'(65536);
    foreach (xs[i]) sum += 128'(xs[i]) * 128'(ws[i]);
    q   = sum >>> 16;
    hi  = 128'(2147483647);
    lo  = -hi - 128'(1);
    sat = (q > hi) || (q < lo);
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
`ifdef FC_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[31:0];
  endfunction

  function automatic logic [31:0] s_expect(input int o, output bit sat);
    int xq[$];
    int wq[$];
    for (int i = 0; i < 8; i++) begin
      xq.push_back(s_x[i]);
      wq.push_back(s_mem[o*9+i]);
    end
    return ref_neuron(xq, wq, s_mem[o*9+8], sat);
  endfunction

  task automatic s_fill(input int x, input int w0, input int b0, input int w1, input int b1);
    for (int i = 0; i < 8; i++) begin
      s_x[i]     = x;
      s_mem[i]   = w0;
      s_mem[9+i] = w1;
    end
    s_mem[8]  = b0;
    s_mem[17] = b1;
  endtask

  // Sends the two beats of s_x; returns at the first cycle of COMPUTE.
  task automatic s_send(input int gap);
    int n;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) s_data_in[j*32 +: 32] = s_x[b*4+j];
      s_valid_in = 1'b1;
      n = 0;
      while (!s_ready_in && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("ready_in_timeout", 64'(n), 64'(0));
      @(negedge clk);
      s_valid_in = 1'b0;
      if (b == 0) begin
        check("after_beat0_busy_ready_ovf", {s_busy, s_ready_in, s_overflow}, 3'b010);
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  // Called at cycle 0 of a neuron with ready_out high; consumes the handshake.
  task automatic s_run_neuron(input string tag, input int o, input logic [31:0] exp);
    int n = 0;
    while (!s_valid_out && n < 200) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 64'(n), 64'(12));
    check({tag, "_data"}, s_data_out, exp);
    check({tag, "_idx"}, s_out_idx, o);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e0, e1;
    bit          sat0, sat1;
    int          n;
    bit          ok;
    logic [31:0] held;
    int          xq[$];
    int          wq[$];

    rst_n = 1'b0;
    s_valid_in = 1'b0; s_data_in = '0; s_ready_out = 1'b0;
    b_valid_in = 1'b0; b_data_in = '0; b_ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_small", {s_ready_in, s_w_rd_en, s_w_addr, s_valid_out, s_data_out,
                          s_out_idx, s_busy, s_overflow}, '0);
    check("reset_big", {b_ready_in, b_w_rd_en, b_w_addr, b_valid_out, b_data_out,
                        b_out_idx, b_busy, b_overflow}, '0);
    rst_n = 1'b1;
    #1 check("ready_in_before_first_clk", s_ready_in, 1'b0);
    @(negedge clk);
    check("ready_in_after_first_clk", s_ready_in, 1'b1);

    // Basic result with a 3-cycle gap between beats and valid_in held while busy.
    s_fill(32'h00010000, 32'h00010000, 0, 32'h00008000, 32'hFFFF0000);
    e0 = s_expect(0, sat0);
    e1 = s_expect(1, sat1);
    s_send(3);
    check("c0_rd_en_addr_busy", {s_w_rd_en, s_w_addr, s_ready_in, s_busy}, {1'b1, 5'd0, 1'b0, 1'b1});
    s_valid_in = 1'b1;
    s_data_in  = '1;
    n = 0; ok = 1'b1;
    while (!s_valid_out && n < 200) begin
      @(negedge clk); n++;
      if (s_ready_in !== 1'b0) ok = 1'b0;
    end
    s_valid_in = 1'b0;
    check("basic_latency", 64'(n), 64'(12));
    check("ready_in_low_while_busy", ok, 1'b1);
    check("basic_n0_data", s_data_out, e0);
    check("basic_n0_idx", s_out_idx, 0);
    check("basic_overflow", s_overflow, sat0);

    // Back-pressure: ready_out low for 5 cycles.
    held = s_data_out; ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (s_valid_out !== 1'b1 || s_data_out !== held || s_out_idx !== 2'd0 || s_w_rd_en !== 1'b0)
        ok = 1'b0;
    end
    check("backpressure_hold", ok, 1'b1);
    s_ready_out = 1'b1;
    @(negedge clk);
    check("n1_starts_after_handshake", {s_valid_out, s_w_rd_en, s_w_addr}, {1'b0, 1'b1, 5'd9});
    s_run_neuron("basic_n1", 1, e1);
    check("back_to_load", {s_valid_out, s_ready_in, s_busy}, 3'b010);

    // Saturation both directions.
    s_fill(32'h7FFF0000, 32'h7FFF0000, 0, 32'h80010000, 0);
    e0 = s_expect(0, sat0);
    e1 = s_expect(1, sat1);
    s_send(0);
    s_run_neuron("sat_pos", 0, e0);
    check("sat_pos_overflow", s_overflow, sat0);
    s_run_neuron("sat_neg", 1, e1);
    check("sat_neg_overflow", s_overflow, sat0 | sat1);

    // Reset in cycle 3 of neuron 0, then a fresh vector.
    s_fill(32'h00020000, 32'h00010000, 0, 32'h00010000, 0);
    e0 = s_expect(0, sat0);
    e1 = s_expect(1, sat1);
    s_send(1);
    repeat (3) @(negedge clk);
    check("pre_abort_busy", {s_busy, s_w_rd_en}, 2'b11);
    rst_n = 1'b0;
    #1 check("abort_outputs", {s_ready_in, s_w_rd_en, s_w_addr, s_valid_out, s_data_out,
                               s_out_idx, s_busy, s_overflow}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_send(0);
    s_run_neuron("after_abort_n0", 0, e0);
    s_run_neuron("after_abort_n1", 1, e1);

    // Full-size random vector.
    for (int i = 0; i < 512; i++) begin
      b_x[i]   = int'($urandom_range(0, 262143)) - 131072;
      b_mem[i] = int'($urandom_range(0, 262143)) - 131072;
      xq.push_back(b_x[i]);
      wq.push_back(b_mem[i]);
    end
    b_mem[512] = int'($urandom_range(0, 131071)) - 65536;
    e0 = ref_neuron(xq, wq, b_mem[512], sat0);
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 128; j++) b_data_in[j*32 +: 32] = b_x[b*128+j];
      b_valid_in = 1'b1;
      n = 0;
      while (!b_ready_in && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("big_ready_timeout", 64'(n), 64'(0));
      @(negedge clk);
      b_valid_in = 1'b0;
    end
    check("big_c0_busy", {b_busy, b_w_rd_en, b_w_addr}, {1'b1, 1'b1, 10'd0});
    n = 0;
    while (!b_valid_out && n < 2000) begin @(negedge clk); n++; end
    check("big_latency", 64'(n), 64'(516));
    check("big_data", b_data_out, e0);
    check("big_idx", b_out_idx, 0);
    check("big_overflow", b_overflow, sat0);
    @(negedge clk);
    check("big_back_to_load", {b_valid_out, b_ready_in}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_param.md
Name: fc_layer_param

Overview:
- Parametrised fully-connected layer; successor to the fixed 512-input, single-output FC stage.
- Collects an input vector over several wide beats, then computes OUTPUT_NUM signed fixed-point dot products, each with bias, using one sequential MAC.
- Weights and biases are read from an external synchronous memory port.
- Results stream out one neuron at a time under a valid/ready handshake.

Parameters:
- INPUT_NUM, 512, input vector length; must be a multiple of IN_LANES (elaboration $fatal otherwise).
- IN_LANES, 128, input elements accepted per beat.
- OUTPUT_NUM, 1, number of output neurons.
- DATA_BITS, 32, width of data, weight, bias and output words (signed two's complement).
- FRAC_BITS, 16, fractional bits of the Q format.
- ACC_BITS, 2*DATA_BITS+$clog2(INPUT_NUM)+1, accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block accepts a beat.
- data_in  in  IN_LANES*DATA_BITS  input beat; lane j occupies bits [j*DATA_BITS +: DATA_BITS]; element index = beat*IN_LANES+j.
- w_rd_en  out  1  weight memory read strobe.
- w_addr  out  $clog2(OUTPUT_NUM*(INPUT_NUM+1))  weight address; row o = o*(INPUT_NUM+1); entries 0..INPUT_NUM-1 are weights, entry INPUT_NUM is the bias.
- w_data  in  DATA_BITS  read data, valid exactly 1 cycle after w_rd_en.
- valid_out  out  1  result valid.
- ready_out  in  1  downstream accepts result.
- data_out  out  DATA_BITS  neuron result.
- out_idx  out  $clog2(OUTPUT_NUM)+1  neuron index of data_out.
- busy  out  1  high in COMPUTE or OUTPUT.
- overflow  out  1  sticky saturation flag; cleared by reset or on a new vector's first beat.

Behaviour:
- Reset values: ready_in=0, w_rd_en=0, w_addr=0, valid_out=0, data_out=0, out_idx=0, busy=0, overflow=0.
- On reset, all counters and the FSM clear.
- The input buffer is not cleared; its contents are don't-care.
- ready_in rises the first clk after rst_n deasserts.
- FSM states: LOAD, COMPUTE, OUTPUT.
- LOAD:
  - ready_in=1.
  - A beat is taken when valid_in && ready_in; it is written into the buffer at beat_cnt*IN_LANES.
  - valid_in while ready_in=0 is ignored; no data is captured.
  - After beat INPUT_NUM/IN_LANES-1 is taken, the FSM goes to COMPUTE next cycle with ready_in=0 and neuron o=0.
- COMPUTE (neuron o):
  - Pipeline: read issue (cycle t) -> w_data arrives (t+1) -> product x[k]*w registered (t+2) -> accumulate (t+3).
  - Cycles 0..INPUT_NUM: w_rd_en=1, w_addr = row o + k, k=0..INPUT_NUM; the k=INPUT_NUM read fetches the bias.
  - Accumulator clears at neuron start.
  - Each product is full 2*DATA_BITS signed, sign-extended to ACC_BITS.
  - Bias is sign-extended and shifted left by FRAC_BITS, then added.
  - Result = acc >>> FRAC_BITS (arithmetic, truncation toward -inf), saturated to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
  - Saturation sets overflow.
  - valid_out asserts exactly INPUT_NUM+4 cycles after COMPUTE entry; the FSM enters OUTPUT.
- OUTPUT:
  - data_out and out_idx are held stable while valid_out && !ready_out.
  - On handshake: if o<OUTPUT_NUM-1, go to COMPUTE with o+1; else go to LOAD and ready_in=1 next cycle.
  - valid_out drops the cycle after the handshake.
- ready_out may be held high permanently; there is no combinational path from ready_out to valid_out.
- Reset mid-COMPUTE or mid-OUTPUT: immediate async abort.
  - The partial result is discarded and valid_out drops at once.
  - After reset the block restarts in LOAD, expecting beat 0.
- The pipeline never stalls inside COMPUTE; the weight memory must honour fixed 1-cycle latency.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: after saturation, a negative result is forced to 0; overflow still reflects saturation.
- Undefined: signed result passes unchanged.
- Latency is identical either way.

Decomposition:
- Package fc_pkg holds the FSM state enum (LOAD, COMPUTE, OUTPUT) and a saturate-and-scale function shared with future layers.
- Natural sub-module: fc_mac_pipe, the 3-stage multiply/accumulate/scale-saturate datapath with clear and last strobes.
- fc_layer_param keeps the FSM, input buffer and address generation.

Test Plan:
- Basic result (INPUT_NUM=8, IN_LANES=4, OUTPUT_NUM=2, DATA_BITS=32, FRAC_BITS=16). All x=0x00010000; row0 weights 0x00010000, bias 0; row1 weights 0x00008000, bias 0xFFFF0000.
  -> out_idx0 data_out=0x00080000; out_idx1 data_out=0x00030000; valid_out 12 cycles after COMPUTE entry; overflow=0.
- Beat counting and timing. Two beats accepted with a valid_in gap of 3 cycles; valid_in held high while busy.
  -> exactly 2 beats captured; ready_in=0 through COMPUTE/OUTPUT; extra beats ignored.
- Saturation. x=0x7FFF0000, w=0x7FFF0000.
  -> data_out=0x7FFFFFFF, overflow=1.
  -> Negated weights give data_out=0x80000000 without FC_RELU_EN, 0x00000000 with it.
- Back-pressure. ready_out held low for 5 cycles.
  -> data_out and out_idx stable, valid_out high, no w_rd_en pulses.
  -> Neuron 1 compute starts the cycle after the handshake.
- Reset mid-COMPUTE. rst_n low at cycle 3 of neuron 0.
  -> all outputs at reset values at once.
  -> A fresh vector (x=0x00020000, w=0x00010000) then gives data_out=0x00100000.
- Full-size check (defaults 512/128/1). 4 beats of random data against the bench model.
  -> bit-exact match; valid_out 516 cycles after COMPUTE entry.
